// File: rtl/time_pkg.sv
// Shared definitions for the time-setting clock controller: mode encodings,
// BCD field limits and the BCD increment-with-wrap helper.
package time_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Two-digit BCD increment that wraps to 00 once the limit is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    if (val >= max) begin
      return 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      return {val[7:4] + 4'd1, 4'd0};
    end else begin
      return {val[7:4], val[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs and time/mode display outputs of the time-setting controller.
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc,
    input  hour_bcd, min_bcd, sec_bcd, mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc,
    output hour_bcd, min_bcd, sec_bcd, mode, blink
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and rising-edge press pulse
// for one raw push button.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that disagree with level_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Hours/minutes/seconds clock with a two-button RUN / SET_HOUR / SET_MIN
// setting interface and a blink enable for the field being edited.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned DB_CYCLES = 500000
) (
  input logic            clk,
  input logic            reset,
  time_set_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

  logic          mode_press;
  logic          inc_press;
  logic          tick;
  logic [PW-1:0] presc_q;
  mode_e         mode_q;
  logic [7:0]    hour_q;
  logic [7:0]    min_q;
  logic [7:0]    sec_q;
  logic          blink_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_mode),
    .press (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_inc),
    .press (inc_press)
  );

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      mode_q  <= MODE_RUN;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      blink_q <= 1'b0;
    end else begin
      blink_q <= (mode_q != MODE_RUN) && (presc_q < PRESC_HALF);

      // Leaving SET_MIN restarts the second so the new time begins on a boundary.
      if (tick || (mode_press && mode_q == MODE_SET_MIN)) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end

      if (mode_press) begin
        unique case (mode_q)
          MODE_RUN:      mode_q <= MODE_SET_HOUR;
          MODE_SET_HOUR: mode_q <= MODE_SET_MIN;
          MODE_SET_MIN: begin
            mode_q <= MODE_RUN;
            sec_q  <= 8'h00;
          end
          default:       mode_q <= MODE_RUN;
        endcase
      end else begin
        unique case (mode_q)
          MODE_RUN: begin
            if (tick) begin
              sec_q <= bcd_inc(sec_q, MINSEC_MAX);
              if (sec_q == MINSEC_MAX) begin
                min_q <= bcd_inc(min_q, MINSEC_MAX);
                if (min_q == MINSEC_MAX) begin
                  hour_q <= bcd_inc(hour_q, HOUR_MAX);
                end
              end
            end
          end
          MODE_SET_HOUR: if (inc_press) hour_q <= bcd_inc(hour_q, HOUR_MAX);
          MODE_SET_MIN:  if (inc_press) min_q <= bcd_inc(min_q, MINSEC_MAX);
          default:       mode_q <= MODE_RUN;
        endcase
      end
    end
  end

  assign bus.hour_bcd = hour_q;
  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.mode     = mode_q;
  assign bus.blink    = blink_q;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per 1 s tick; SHALL be >= 2.
REQ-002 Parameter DB_CYCLES, default 500000: cycles a synchronized button must be stable to be accepted; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
REQ-006 btn_inc  input  1  raw increment button, active-high, asynchronous to clk.
REQ-007 hour_bcd  output  8  hours, two BCD digits, 00-23.
REQ-008 min_bcd  output  8  minutes, two BCD digits, 00-59.
REQ-009 sec_bcd  output  8  seconds, two BCD digits, 00-59.
REQ-010 mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-011 blink  output  1  display blink enable for the field being set.

Function
REQ-012 Each button SHALL pass a 2-FF synchronizer, then a debouncer that updates its debounced level only after DB_CYCLES consecutive identical synchronized samples.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced level's 0->1 edge; holding a button SHALL produce no further events.
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 continuously and wrap; tick SHALL pulse for one cycle at count TICK_DIV-1.
REQ-015 FSM SHALL be RUN -> SET_HOUR -> SET_MIN -> RUN, advancing one state per mode press.
REQ-016 In RUN, each tick SHALL increment sec; 59->00 carries to min; min 59->00 carries to hour; hour 23->00; 23:59:59 SHALL roll to 00:00:00 in one tick.
REQ-017 In SET_HOUR and SET_MIN, ticks SHALL be ignored and sec held.
REQ-018 In SET_HOUR, an inc press SHALL increment hour, 23->00, with no other field affected.
REQ-019 In SET_MIN, an inc press SHALL increment min, 59->00, with no carry into hour.
REQ-020 In RUN, inc presses SHALL be ignored.
REQ-021 On the SET_MIN->RUN transition, sec SHALL be cleared to 00 and the prescaler cleared to 0, the same cycle.
REQ-022 Mode and inc press in the same cycle: mode SHALL take effect, inc SHALL be dropped.
REQ-023 blink SHALL be 1 in a SET state while prescaler count < TICK_DIV/2, otherwise 0; in RUN blink SHALL be 0.
REQ-024 All BCD digits SHALL remain valid (each nibble 0-9) at all times; outputs SHALL be registered.
REQ-025 State, time, mode, and blink updates SHALL take effect on the clk edge after the event cycle: one cycle of latency.

Reset
REQ-026 reset asserted SHALL immediately force hour/min/sec = 00, mode = RUN, blink = 0, prescaler = 0, synchronizers/debounced levels = 0, with no press event pending.
REQ-027 Reset mid-debounce or mid-SET SHALL discard all progress; after release, operation SHALL resume from REQ-026 values on the next clk edge.

Structure
REQ-028 Shared package/include time_pkg SHALL hold mode encodings (MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN) and BCD limits (HOUR_MAX 8'h23, MINSEC_MAX 8'h59).
REQ-029 Sub-module btn_debounce (synchronizer + stability counter + edge pulse, parameter DB_CYCLES) SHALL be instantiated once per button.
REQ-030 BCD increment-with-limit SHALL be a single reused function/task, not per-field duplicated logic.

Verification (TICK_DIV=10, DB_CYCLES=3)
REQ-031 Reset then 600 cycles in RUN -> sec_bcd=8'h00, min_bcd=8'h01 after 60 ticks; mode=00, blink=0 throughout.
REQ-032 Preload 23:59:59 via SET path, run -> next tick yields 00:00:00 in one cycle.
REQ-033 Mode press, 5 inc presses, mode press, 61 inc presses, mode press -> hour 05, min 01, sec 00, mode 00, prescaler restarted.
REQ-034 btn_mode glitching high for 2 cycles -> no event, mode unchanged; held high 100 cycles -> exactly one transition.
REQ-035 btn_mode and btn_inc events on the same cycle in SET_HOUR -> mode=10, hour unchanged.
REQ-036 reset asserted asynchronously mid-SET_MIN between clk edges -> outputs 00:00:00, mode 00 before next clk edge.
